// File: rtl/e_digit_emitter.sv
// e_digit_emitter: converts the fractional part of a 400-bit fixed-point
// value to a decimal digit stream by repeated multiply-by-10, preceded by
// the integer digit. Digits leave on a valid/ready handshake.
module e_digit_emitter #(
  parameter int unsigned FRAC_BITS  = 392,
  parameter int unsigned NUM_DIGITS = 100
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [399:0] value,
  output logic         busy,
  output logic         digit_valid,
  input  logic         digit_ready,
  output logic [3:0]   digit,
  output logic         digit_is_int,
  output logic         digit_last,
  output logic         int_err,
  output logic         done
);

  localparam int unsigned VALUE_W = 400;
  localparam int unsigned INT_W   = VALUE_W - FRAC_BITS;
  localparam int unsigned CNT_W   = 8;

  typedef enum logic [1:0] {
    IDLE,
    EMIT,
    MUL,
    DONE
  } state_t;

  state_t               state;
  logic [FRAC_BITS-1:0] frac;
  logic [CNT_W-1:0]     cnt;

  logic [INT_W-1:0]     int_field;
  logic                 int_ovf;
  logic [FRAC_BITS+3:0] prod;
  logic [CNT_W:0]       cnt_next;
  logic                 handshake;

  // Integer field of the incoming value and its single-digit range check.
  assign int_field = value[VALUE_W-1:FRAC_BITS];
  assign int_ovf   = (int_field >= INT_W'(10));

  // frac*10 as (frac<<3)+(frac<<1); the top 4 bits are the next digit.
  assign prod = {1'b0, frac, 3'b000} + {3'b000, frac, 1'b0};

  assign cnt_next  = (CNT_W+1)'(cnt) + (CNT_W+1)'(1);
  assign handshake = digit_valid && digit_ready;

  // Conversion FSM with registered stream payload and status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      frac         <= '0;
      cnt          <= '0;
      busy         <= 1'b0;
      digit_valid  <= 1'b0;
      digit        <= 4'h0;
      digit_is_int <= 1'b0;
      digit_last   <= 1'b0;
      int_err      <= 1'b0;
      done         <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            frac         <= value[FRAC_BITS-1:0];
            cnt          <= '0;
            digit        <= int_ovf ? 4'hF : int_field[3:0];
            int_err      <= int_ovf;
            digit_is_int <= 1'b1;
            digit_last   <= 1'b0;
            digit_valid  <= 1'b1;
            busy         <= 1'b1;
            done         <= 1'b0;
            state        <= EMIT;
          end
        end
        EMIT: begin
          if (handshake) begin
            digit_valid <= 1'b0;
            if (digit_last) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              state <= MUL;
            end
          end
        end
        MUL: begin
          digit        <= prod[FRAC_BITS+3:FRAC_BITS];
          frac         <= prod[FRAC_BITS-1:0];
          cnt          <= cnt_next[CNT_W-1:0];
          digit_is_int <= 1'b0;
          digit_last   <= (cnt_next == (CNT_W+1)'(NUM_DIGITS));
          digit_valid  <= 1'b1;
          state        <= EMIT;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_e_digit_emitter.sv
// Self-checking bench for e_digit_emitter: table-driven full conversions
// plus hand-written sequences for stalls, ignored start, reset and a
// short NUM_DIGITS instance.
module tb_e_digit_emitter;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [399:0] value;
  logic         ready;
  logic         busy, digit_valid, digit_is_int, digit_last, int_err, done;
  logic [3:0]   digit;

  logic         start4;
  logic [399:0] value4;
  logic         ready4;
  logic         busy4, valid4, is_int4, last4, err4, done4;
  logic [3:0]   digit4;

  always #5 clk = ~clk;

  e_digit_emitter dut (
    .clk(clk), .rst(rst), .start(start), .value(value),
    .busy(busy), .digit_valid(digit_valid), .digit_ready(ready),
    .digit(digit), .digit_is_int(digit_is_int), .digit_last(digit_last),
    .int_err(int_err), .done(done)
  );

  e_digit_emitter #(.FRAC_BITS(392), .NUM_DIGITS(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .value(value4),
    .busy(busy4), .digit_valid(valid4), .digit_ready(ready4),
    .digit(digit4), .digit_is_int(is_int4), .digit_last(last4),
    .int_err(err4), .done(done4)
  );

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask

  typedef struct {
    logic [399:0] val;
    logic [3:0]   int_dig;
    logic         err;
    logic [31:0]  head;   // first 8 fractional digits, first digit in [31:28]
    logic [3:0]   tail;   // expected value of fractional digits 9..100
  } vec_t;

  vec_t tv[8];

  int   rec_digit[0:100];
  bit   rec_int[0:100];
  bit   rec_last[0:100];
  int   rec_n;
  int   rec_cycles;

  // Runs one conversion on the default instance, recording the stream.
  task automatic run_conv(input logic [399:0] v, input int stall_idx,
                          input int stall_len, input int restart_idx);
    int n, stalled, guard;
    bit restarted;
    logic [5:0] snap;
    @(negedge clk);
    value = v; start = 1'b1; ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; value = ~v;
    n = 0; stalled = 0; guard = 0; restarted = 0; rec_cycles = 1; snap = '0;
    while (!done && guard < 4000) begin
      start = 1'b0;
      if (!restarted && n == restart_idx) begin
        start = 1'b1; value = '0; restarted = 1;
      end
      if (n == stall_idx && stalled > 0)
        chk("stall_hold", {digit_valid, digit, digit_is_int, digit_last}, {1'b1, snap});
      if (digit_valid) begin
        if (n == stall_idx && stalled < stall_len) begin
          if (stalled == 0) snap = {digit, digit_is_int, digit_last};
          ready = 1'b0;
          stalled++;
        end else begin
          ready = 1'b1;
          if (n <= 100) begin
            rec_digit[n] = int'(digit);
            rec_int[n]   = digit_is_int;
            rec_last[n]  = digit_last;
          end
          n++;
        end
      end
      @(posedge clk); #1;
      rec_cycles++;
      guard++;
    end
    start = 1'b0;
    rec_n = n;
    chk("done_reached", 64'(done), 64'd1);
    chk("digit_count", 64'(n), 64'd101);
    chk("busy_after", 64'(busy), 64'd0);
  endtask

  // Flag placement: is_int only on the first digit, last only on the 101st.
  task automatic chk_flags(input string tag);
    int ni, nl;
    ni = 0; nl = 0;
    for (int i = 0; i <= 100; i++) begin
      if (rec_int[i]) ni++;
      if (rec_last[i]) nl++;
    end
    chk({tag, "_is_int0"}, 64'(rec_int[0]), 64'd1);
    chk({tag, "_is_int_count"}, 64'(ni), 64'd1);
    chk({tag, "_last100"}, 64'(rec_last[100]), 64'd1);
    chk({tag, "_last_count"}, 64'(nl), 64'd1);
  endtask

  logic [399:0] one, e_val, term;
  string        e_ref;
  logic [31:0]  h;
  logic [3:0]   exp_d;

  initial begin
    rst = 1'b1; start = 1'b0; value = '0; ready = 1'b0;
    start4 = 1'b0; value4 = '0; ready4 = 1'b0;
    for (int i = 0; i <= 100; i++) begin
      rec_digit[i] = 0; rec_int[i] = 0; rec_last[i] = 0;
    end

    one = 400'd1 << 392;
    tv[0] = '{one,                                        4'd1, 1'b0, 32'h0000_0000, 4'd0};
    tv[1] = '{one >> 1,                                   4'd0, 1'b0, 32'h5000_0000, 4'd0};
    tv[2] = '{one >> 4,                                   4'd0, 1'b0, 32'h0625_0000, 4'd0};
    tv[3] = '{9 * one + (one >> 1) + (one >> 2) + (one >> 3), 4'd9, 1'b0, 32'h8750_0000, 4'd0};
    tv[4] = '{12 * one + (one >> 1),                      4'hF, 1'b1, 32'h5000_0000, 4'd0};
    tv[5] = '{one,                                        4'd1, 1'b0, 32'h0000_0000, 4'd0};
    tv[6] = '{10 * one,                                   4'hF, 1'b1, 32'h0000_0000, 4'd0};
    tv[7] = '{{400{1'b1}},                                4'hF, 1'b1, 32'h9999_9999, 4'd9};

    // e = sum of 1/k! for k = 0..70 in the same fixed-point format
    term = one; e_val = one;
    for (int k = 1; k <= 70; k++) begin
      term  = term / 400'(k);
      e_val = e_val + term;
    end
    e_ref = {"7182818284", "5904523536", "0287471352", "6624977572", "4709369995",
             "9574966967", "6277240766", "3035354759", "4571382178", "5251664274"};

    // Reset state of both instances
    #12;
    chk("reset_outputs", {busy, digit_valid, digit, digit_is_int, digit_last, int_err, done}, '0);
    chk("reset_outputs4", {busy4, valid4, digit4, is_int4, last4, err4, done4}, '0);
    @(negedge clk); rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_no_valid", 64'(digit_valid), 64'd0);

    // Table-driven full conversions with ready tied high
    for (int j = 0; j < 8; j++) begin
      run_conv(tv[j].val, -1, 0, -1);
      chk($sformatf("v%0d_int_digit", j), 64'(rec_digit[0]), 64'(tv[j].int_dig));
      chk($sformatf("v%0d_int_err", j), 64'(int_err), 64'(tv[j].err));
      chk($sformatf("v%0d_cycles", j), 64'(rec_cycles), 64'd202);
      chk_flags($sformatf("v%0d", j));
      h = tv[j].head;
      for (int i = 1; i <= 100; i++) begin
        exp_d = (i <= 8) ? h[31-4*(i-1) -: 4] : tv[j].tail;
        chk($sformatf("v%0d_digit%0d", j, i), 64'(rec_digit[i]), 64'(exp_d));
      end
    end

    // e with a 5-cycle stall on the 3rd digit and a start while busy
    run_conv(e_val, 2, 5, 20);
    chk("e_int_digit", 64'(rec_digit[0]), 64'd2);
    chk("e_int_err", 64'(int_err), 64'd0);
    chk("e_cycles", 64'(rec_cycles), 64'd207);
    chk_flags("e");
    for (int i = 1; i <= 100; i++)
      chk($sformatf("e_digit%0d", i), 64'(rec_digit[i]), 64'(int'(e_ref[i-1]) - 48));

    // Reset after the 10th handshake abandons the stream
    begin
      int hs, guard, saw;
      @(negedge clk);
      value = e_val; start = 1'b1; ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      hs = 0; guard = 0;
      while (hs < 10 && guard < 200) begin
        if (digit_valid) hs++;
        @(posedge clk); #1;
        guard++;
      end
      chk("rst_reached_10", 64'(hs), 64'd10);
      rst = 1'b1;
      #1;
      chk("rst_midstream", {busy, digit_valid, digit, digit_is_int, digit_last, int_err, done}, '0);
      @(negedge clk); rst = 1'b0;
      saw = 0;
      repeat (20) begin
        @(negedge clk);
        if (digit_valid || busy || done) saw++;
      end
      chk("rst_no_valid_after", 64'(saw), 64'd0);
    end

    // NUM_DIGITS = 4 instance, value 0.75: stream 0,7,5,0,0
    begin
      int n, guard, cyc;
      int d4[0:4];
      bit l4[0:4];
      for (int i = 0; i <= 4; i++) begin d4[i] = -1; l4[i] = 0; end
      @(negedge clk);
      value4 = (one >> 1) + (one >> 2); start4 = 1'b1; ready4 = 1'b1;
      @(posedge clk); #1;
      start4 = 1'b0; value4 = '0;
      n = 0; guard = 0; cyc = 1;
      while (!done4 && guard < 200) begin
        if (valid4 && n <= 4) begin
          d4[n] = int'(digit4); l4[n] = last4; n++;
        end
        @(posedge clk); #1;
        cyc++; guard++;
      end
      chk("n4_count", 64'(n), 64'd5);
      chk("n4_cycles", 64'(cyc), 64'd10);
      chk("n4_digits", {16'(d4[0]), 16'(d4[1]), 16'(d4[2]), 16'(d4[3]), 16'(d4[4])},
          {16'd0, 16'd7, 16'd5, 16'd0, 16'd0});
      chk("n4_last", {l4[0], l4[1], l4[2], l4[3], l4[4]}, 5'b00001);
      chk("n4_done_static", {busy4, valid4, done4}, 3'b001);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/e_digit_emitter.md
# e_digit_emitter

Downstream consumer of the e calculator. It takes the finished 400-bit fixed-point result and converts its fractional part to decimal one digit at a time, by repeated multiply-by-10. The digits leave on a valid/ready stream that feeds the display or UART formatter. One conversion runs per `start`; the block holds no state between conversions.

## Interface
- `FRAC_BITS`, default 392: number of fractional bits in `value`. The integer field is `value[399:FRAC_BITS]`, which is 8 bits wide at the default.
- `NUM_DIGITS`, default 100: number of fractional digits to emit. Legal range 1..255.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  one-cycle request. Sampled only in IDLE or DONE; ignored otherwise.
- `value`  in  400  fixed-point input. Numeric value is `value / 2^FRAC_BITS`. Captured on the accepted `start` edge only.
- `busy`  out  1  high from the accepted `start` until entry to DONE.
- `digit_valid`  out  1  `digit` and its flags are presented.
- `digit_ready`  in  1  consumer accepts. A handshake occurs on an edge where `digit_valid && digit_ready`.
- `digit`  out  4  BCD digit 0..9, or 4'hF for integer overflow.
- `digit_is_int`  out  1  high while the integer digit is presented.
- `digit_last`  out  1  high while the final fractional digit is presented.
- `int_err`  out  1  sticky for the conversion: integer field was ≥ 10. Cleared on the next accepted `start`.
- `done`  out  1  level, high in DONE until the next accepted `start`.

## Operation
States: IDLE, EMIT, MUL, DONE.
- **Reset:** state IDLE. All outputs 0: `busy`, `digit_valid`, `digit`, `digit_is_int`, `digit_last`, `int_err`, `done`. Internal fraction register and counter cleared.
- **IDLE or DONE with `start`:**
  - `frac <= value[FRAC_BITS-1:0]`, `cnt <= 0`.
  - Integer field `I = value[399:FRAC_BITS]`: `digit <= I[3:0]` if `I < 10`, else `digit <= 4'hF` and `int_err <= 1`.
  - `digit_is_int <= 1`, `digit_valid <= 1`, `busy <= 1`, `done <= 0`; go to EMIT.
- **EMIT:** hold `digit`, `digit_is_int` and `digit_last` stable while `digit_ready` is low. On handshake, `digit_valid <= 0`, then:
  - if `digit_last` is set, go to DONE, with `busy <= 0` and `done <= 1`;
  - otherwise go to MUL.
- **MUL (exactly one cycle):**
  - Compute `p = (frac << 3) + (frac << 1)`, width `FRAC_BITS+4`.
  - `digit <= p[FRAC_BITS+3:FRAC_BITS]`; this is always 0..9.
  - `frac <= p[FRAC_BITS-1:0]`, `cnt <= cnt + 1`.
  - `digit_is_int <= 0`, `digit_last <= (cnt + 1 == NUM_DIGITS)`, `digit_valid <= 1`; go to EMIT.
- **DONE:** outputs static, `done = 1`. A `start` restarts exactly as from IDLE.
- **Digit count:** one integer digit plus `NUM_DIGITS` fractional digits. `digit_last` is never set on the integer digit.
- **Input stability:** `value` may change freely after capture.
- **Arithmetic:** the multiply-by-10 is lossless. The fraction stays exactly `FRAC_BITS` wide, with no rounding and no truncation beyond the emitted digit.

## Timing
- **First digit:** the integer digit is valid in the cycle after the accepted `start` edge.
- **Next digit:** after a handshake at edge k, `digit_valid` is low for one cycle (MUL) and high again after edge k+2. Peak throughput is 1 digit per 2 cycles.
- **Minimum total:** a full conversion with `digit_ready` tied high takes `2*NUM_DIGITS + 2` cycles from `start` to `done` high (202 at defaults).
- **Handshake rules:**
  - `digit_valid` never deasserts without a handshake.
  - The payload never changes while valid and not accepted.
- **`start` while busy:** no effect on any state or output.
- **`rst` mid-conversion:** immediate return to the reset values above. The partial stream is abandoned, and there is no further `digit_valid` until a new `start`.
- **`start` in the same cycle as the last handshake:** the state is EMIT, so `start` is ignored. A new conversion needs `start` in DONE.

## Test plan
- **value = 1.0** (`value = 1 << 392`), `digit_ready = 1`: stream 1 (`is_int`), then 100 × 0. `digit_last` on the 101st digit; `done` high at cycle 202; `int_err = 0`.
- **value = 0.75** (bits 391 and 390 set), `NUM_DIGITS = 4`: stream 0, 7, 5, 0, 0. `digit_last` only on the final 0.
- **value = e** (output of the e calculator after 70 terms):
  - first 13 digits are 2, 7, 1, 8, 2, 8, 1, 8, 2, 8, 4, 5, 9;
  - all 100 fractional digits match the reference constant.
- **Backpressure:** `digit_ready` low for 5 cycles on the 3rd digit. `digit` and flags stay constant and `digit_valid` stays high; the stream content is identical to the run with no stalls.
- **Integer overflow:** integer field = 12, fraction 0.5. First digit 4'hF with `is_int`, `int_err = 1`, then 5, 0, ... `int_err` clears on the next `start`.
- **Reset and ignored start:**
  - `rst` pulsed after the 10th handshake: all outputs return to 0 and no `digit_valid` follows.
  - A `start` asserted while `busy` mid-stream does not alter the digit sequence.
